scr1_dbgc_hart_seq: RTL
=======================

SCR1_DBGC_HART_SEQ -- requirements
Module: scr1_dbgc_hart_seq

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 256, max cycles to wait for re-halt after EXEC/STEP run ack; power of 2, >=4.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 rst_n  in  1  async active-low reset.
REQ-004 clk  in  1  clock.
REQ-005 host_op_req  in  1  op request, accepted only when host_busy=0.
REQ-006 host_op  in  2  0 HALT, 1 RUN, 2 EXEC (run one DBGC-supplied instr), 3 STEP (run one core instr).
REQ-007 host_runctrl  in  type_scr1_dbgc_hart_runctrl_s  base run control.
REQ-008 host_instr  in  SCR1_DBGC_DBG_CORE_INSTR_WIDTH  instr for EXEC.
REQ-009 host_ddr_wdata / host_ddr_we  in  SCR1_DBGC_DBG_DATA_REG_WIDTH / 1  DDR write from host.
REQ-010 host_busy  out  1  op in progress.
REQ-011 host_done  out  1  one-cycle completion pulse.
REQ-012 host_status  out  2  0 OK, 1 NACK, 2 TIMEOUT, 3 EXCEPT; valid from host_done until next accept.
REQ-013 host_ddr_rdata  out  SCR1_DBGC_DBG_DATA_REG_WIDTH  last core-written DDR value.
REQ-014 host_ddr_upd  out  1  one-cycle pulse when host_ddr_rdata updated.
REQ-015 dbgc_hart_cmd  out  type_scr1_dbgc_hart_dbg_mode_e  requested mode.
REQ-016 dbgc_hart_cmd_req  out  1  command request.
REQ-017 dbgc_hart_cmd_ack / dbgc_hart_cmd_nack  in  1 / 1  hart response.
REQ-018 dbgc_hart_runctrl  out  type_scr1_dbgc_hart_runctrl_s  registered run control.
REQ-019 dbgc_hart_state  in  type_scr1_dbgc_hart_state_s  hart state.
REQ-020 dbgc_hart_instr  out  SCR1_DBGC_DBG_CORE_INSTR_WIDTH  registered instr.
REQ-021 dbgc_hart_dreg_out  out  SCR1_DBGC_DBG_DATA_REG_WIDTH  DDR DBGC->core.
REQ-022 dbgc_hart_dreg_in / dbgc_hart_dreg_wr  in  SCR1_DBGC_DBG_DATA_REG_WIDTH / 1  DDR core->DBGC.

Function
REQ-023 FSM states IDLE, REQ, WAIT_HALT, DONE.
REQ-024 IDLE: host_op_req -> latch op, load dbgc_hart_runctrl/dbgc_hart_instr, go REQ; host_busy=1 from next cycle.
REQ-025 Runctrl load: HALT/RUN = host_runctrl; EXEC = host_runctrl with fetch_src=DBGC, dmode_en.sstep=1; STEP = host_runctrl with fetch_src=core, dmode_en.sstep=1.
REQ-026 dbgc_hart_runctrl and dbgc_hart_instr stable from REQ entry through DONE; never change while cmd_req=1.
REQ-027 REQ: cmd_req=1, cmd = DBG_MODE for HALT else RUN_MODE; held until ack or nack sampled; cmd_req=0 the following cycle.
REQ-028 ack and nack in same cycle: nack wins.
REQ-029 REQ exits: nack -> DONE, status TIMEOUT if op=HALT and dbgc_hart_state.timeout=1, else NACK; ack with HALT/RUN -> DONE status OK; ack with EXEC/STEP -> WAIT_HALT.
REQ-030 WAIT_HALT: watchdog loaded WAIT_TIMEOUT-1 on entry, decrement per cycle; halted=1 -> DONE, status EXCEPT if dbgc_hart_state.except=1 else OK; watchdog 0 without halted -> DONE, status TIMEOUT.
REQ-031 DONE: host_done=1 one cycle, then IDLE; host_busy=0 in DONE cycle's successor.
REQ-032 host_op_req while busy ignored, no queueing.
REQ-033 host_ddr_we -> dbgc_hart_dreg_out updated next cycle, any state.
REQ-034 dbgc_hart_dreg_wr -> host_ddr_rdata captured next cycle, host_ddr_upd pulses; host write and core write same cycle both take effect (separate registers).
REQ-035 Sim-only assertion: ack or nack while cmd_req=0 flagged as error.

Reset
REQ-036 Reset: state IDLE, cmd_req=0, cmd=RUN_MODE, host_busy=0, host_done=0, host_status=0, host_ddr_upd=0, runctrl/instr/dreg_out/host_ddr_rdata all-zero.
REQ-037 Reset mid-operation aborts immediately; no host_done issued.

Verification
REQ-038 HALT, hart acks in 3rd REQ cycle -> cmd_req high 3 cycles, host_done one cycle later, status 0.
REQ-039 RUN while hart running -> nack -> status 1; HALT nack with state.timeout=1 -> status 2.
REQ-040 EXEC instr 0x0000_0013 -> runctrl.fetch_src=DBGC, sstep=1, instr driven; ack, halted after 2 cycles -> status 0; with except=1 -> status 3.
REQ-041 STEP, hart never re-halts, WAIT_TIMEOUT=8 -> host_done 8 cycles after WAIT_HALT entry, status 2.
REQ-042 ack+nack same cycle -> status 1; host_op_req during busy -> no second op.
REQ-043 dreg_wr 0xDEADBEEF with simultaneous host_ddr_we 0x1234 -> rdata 0xDEADBEEF, dreg_out 0x1234; rst_n low in WAIT_HALT -> IDLE, cmd_req=0, no host_done.

Source files
------------

// File: rtl/scr1_dbgc_hart_seq.sv
// Debug controller hart sequencer: turns one host HALT/RUN/EXEC/STEP request into a
// hart command handshake, optional re-halt wait, and a single completion pulse.
package scr1_dbgc_hart_seq_pkg;
    localparam int unsigned SCR1_DBGC_DBG_CORE_INSTR_WIDTH = 32;
    localparam int unsigned SCR1_DBGC_DBG_DATA_REG_WIDTH   = 32;

    localparam logic FETCH_SRC_CORE = 1'b0;
    localparam logic FETCH_SRC_DBGC = 1'b1;

    typedef enum logic [1:0] {
        RUN_MODE = 2'd0,
        DBG_MODE = 2'd1
    } type_scr1_dbgc_hart_dbg_mode_e;

    typedef struct packed {
        logic sstep;
        logic brkpt;
    } type_scr1_dbgc_hart_dmode_en_s;

    typedef struct packed {
        logic                          irq_dsbl;
        logic                          fetch_src;
        logic                          pc_advmt_dsbl;
        logic                          hwbrkpt_dsbl;
        type_scr1_dbgc_hart_dmode_en_s dmode_en;
    } type_scr1_dbgc_hart_runctrl_s;

    typedef struct packed {
        logic halted;
        logic timeout;
        logic except;
    } type_scr1_dbgc_hart_state_s;
endpackage

module scr1_dbgc_hart_seq
    import scr1_dbgc_hart_seq_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 256
) (
    input  logic                                        rst_n,
    input  logic                                        clk,
    input  logic                                        host_op_req,
    input  logic [1:0]                                  host_op,
    input  type_scr1_dbgc_hart_runctrl_s                host_runctrl,
    input  logic [SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0]   host_instr,
    input  logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]     host_ddr_wdata,
    input  logic                                        host_ddr_we,
    output logic                                        host_busy,
    output logic                                        host_done,
    output logic [1:0]                                  host_status,
    output logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]     host_ddr_rdata,
    output logic                                        host_ddr_upd,
    output type_scr1_dbgc_hart_dbg_mode_e               dbgc_hart_cmd,
    output logic                                        dbgc_hart_cmd_req,
    input  logic                                        dbgc_hart_cmd_ack,
    input  logic                                        dbgc_hart_cmd_nack,
    output type_scr1_dbgc_hart_runctrl_s                dbgc_hart_runctrl,
    input  type_scr1_dbgc_hart_state_s                  dbgc_hart_state,
    output logic [SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0]   dbgc_hart_instr,
    output logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]     dbgc_hart_dreg_out,
    input  logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]     dbgc_hart_dreg_in,
    input  logic                                        dbgc_hart_dreg_wr
);
    localparam int unsigned WDOG_W = $clog2(WAIT_TIMEOUT);

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_EXEC = 2'd2;
    localparam logic [1:0] OP_STEP = 2'd3;

    localparam logic [1:0] STS_OK      = 2'd0;
    localparam logic [1:0] STS_NACK    = 2'd1;
    localparam logic [1:0] STS_TIMEOUT = 2'd2;
    localparam logic [1:0] STS_EXCEPT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_HALT,
        ST_DONE
    } state_e;

    state_e                                     state_q, state_d;
    logic [1:0]                                 op_q, op_d;
    type_scr1_dbgc_hart_dbg_mode_e              cmd_q, cmd_d;
    logic                                       cmd_req_q, cmd_req_d;
    logic                                       busy_q, busy_d;
    logic                                       done_q, done_d;
    logic [1:0]                                 status_q, status_d;
    logic [WDOG_W-1:0]                          wdog_q, wdog_d;
    type_scr1_dbgc_hart_runctrl_s               runctrl_q, runctrl_d;
    logic [SCR1_DBGC_DBG_CORE_INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]    dreg_out_q, dreg_out_d;
    logic [SCR1_DBGC_DBG_DATA_REG_WIDTH-1:0]    rdata_q, rdata_d;
    logic                                       upd_q, upd_d;

    logic op_single;
    assign op_single = (op_q == OP_EXEC) || (op_q == OP_STEP);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cmd_d      = cmd_q;
        cmd_req_d  = cmd_req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        status_d   = status_q;
        wdog_d     = wdog_q;
        runctrl_d  = runctrl_q;
        instr_d    = instr_q;
        dreg_out_d = host_ddr_we ? host_ddr_wdata : dreg_out_q;
        rdata_d    = dbgc_hart_dreg_wr ? dbgc_hart_dreg_in : rdata_q;
        upd_d      = dbgc_hart_dreg_wr;

        case (state_q)
            ST_IDLE: begin
                if (host_op_req) begin
                    state_d   = ST_REQ;
                    op_d      = host_op;
                    busy_d    = 1'b1;
                    cmd_req_d = 1'b1;
                    cmd_d     = (host_op == OP_HALT) ? DBG_MODE : RUN_MODE;
                    runctrl_d = host_runctrl;
                    instr_d   = host_instr;
                    // Single-instruction ops force single-step and pick the fetch source
                    if ((host_op == OP_EXEC) || (host_op == OP_STEP)) begin
                        runctrl_d.fetch_src      = (host_op == OP_EXEC) ? FETCH_SRC_DBGC : FETCH_SRC_CORE;
                        runctrl_d.dmode_en.sstep = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (dbgc_hart_cmd_nack) begin
                    cmd_req_d = 1'b0;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    status_d  = ((op_q == OP_HALT) && dbgc_hart_state.timeout) ? STS_TIMEOUT : STS_NACK;
                end else if (dbgc_hart_cmd_ack) begin
                    cmd_req_d = 1'b0;
                    if (op_single) begin
                        state_d = ST_WAIT_HALT;
                        wdog_d  = WDOG_W'(WAIT_TIMEOUT - 1);
                    end else begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        status_d = STS_OK;
                    end
                end
            end
            ST_WAIT_HALT: begin
                if (dbgc_hart_state.halted) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    status_d = dbgc_hart_state.except ? STS_EXCEPT : STS_OK;
                end else if (wdog_q == '0) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    status_d = STS_TIMEOUT;
                end else begin
                    wdog_d = wdog_q - WDOG_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cmd_q      <= RUN_MODE;
            cmd_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= '0;
            wdog_q     <= '0;
            runctrl_q  <= '0;
            instr_q    <= '0;
            dreg_out_q <= '0;
            rdata_q    <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cmd_q      <= cmd_d;
            cmd_req_q  <= cmd_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            status_q   <= status_d;
            wdog_q     <= wdog_d;
            runctrl_q  <= runctrl_d;
            instr_q    <= instr_d;
            dreg_out_q <= dreg_out_d;
            rdata_q    <= rdata_d;
            upd_q      <= upd_d;
        end
    end

    assign host_busy          = busy_q;
    assign host_done          = done_q;
    assign host_status        = status_q;
    assign host_ddr_rdata     = rdata_q;
    assign host_ddr_upd       = upd_q;
    assign dbgc_hart_cmd      = cmd_q;
    assign dbgc_hart_cmd_req  = cmd_req_q;
    assign dbgc_hart_runctrl  = runctrl_q;
    assign dbgc_hart_instr    = instr_q;
    assign dbgc_hart_dreg_out = dreg_out_q;

`ifndef SYNTHESIS
    hart_resp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        (dbgc_hart_cmd_ack || dbgc_hart_cmd_nack) |-> cmd_req_q)
        else $error("hart ack/nack seen with no command request pending");
`endif

endmodule
